bias_rf_loader: RTL and testbench

//  Upstream fill stage for bias_rf_control: accepts a serial 16-bit bias stream (valid/ready) for one layer.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/bias_rf_loader.sv | 139 +++++++++++++
 tb/tb_bias_rf_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: bias register-file geometry and the
// bias loader state encoding.
package cnn_pkg;

    localparam int unsigned BIAS_W      = 16;
    localparam int unsigned BIAS_ADDR_W = 4;
    localparam int unsigned BIAS_LANES  = 4;
    localparam int unsigned BIAS_CNT_W  = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_e;

endpackage : cnn_pkg

// File: rtl/bias_rf_loader.sv
// bias_rf_loader: fill stage for the bias register file. Accepts a serial
// bias stream for one layer, stages four channels at a time and issues one
// 4-lane SRAM write per group (channel c -> lane c%4, address c/4).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   load_start/load_num  start pulse and channel count (sampled in IDLE only)
//   bias_in_*            valid/ready bias word stream, channel order 0,1,2,...
//   bias_rf_en/_wr_en    SRAM CEN / WEN, active-low, low only in the write cycle
//   bias_rf_wr_addr      group write address
//   bias_rfN_wr_data     lane N write data (N = 1..4)
//   busy                 load in progress (COLLECT/WRITE/DONE)
//   load_done            one-cycle pulse after the final write
module bias_rf_loader
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = BIAS_W,
    parameter int unsigned ADDR_W = BIAS_ADDR_W,
    parameter int unsigned CNT_W  = BIAS_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [CNT_W-1:0]  load_num,
    input  logic              bias_in_valid,
    output logic              bias_in_ready,
    input  logic [DATA_W-1:0] bias_in_data,
    output logic              bias_rf_en,
    output logic              bias_rf_wr_en,
    output logic [ADDR_W-1:0] bias_rf_wr_addr,
    output logic [DATA_W-1:0] bias_rf1_wr_data,
    output logic [DATA_W-1:0] bias_rf2_wr_data,
    output logic [DATA_W-1:0] bias_rf3_wr_data,
    output logic [DATA_W-1:0] bias_rf4_wr_data,
    output logic              busy,
    output logic              load_done
);

    localparam int unsigned MAX_N = BIAS_LANES * (2 ** ADDR_W);

    loader_state_e     state;
    logic [CNT_W-1:0]  n;
    logic [CNT_W-1:0]  count;
    logic [1:0]        lane_idx;
    logic [DATA_W-1:0] stage [BIAS_LANES];

    logic              hs;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  n_clamped;

    assign hs        = bias_in_valid & bias_in_ready;
    assign cnt_inc   = count + CNT_W'(1);
    assign n_clamped = (load_num > CNT_W'(MAX_N)) ? CNT_W'(MAX_N) : load_num;

    // Loader FSM; the write address doubles as the group counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            n                <= '0;
            count            <= '0;
            lane_idx         <= '0;
            bias_in_ready    <= 1'b0;
            bias_rf_en       <= 1'b1;
            bias_rf_wr_en    <= 1'b1;
            bias_rf_wr_addr  <= '0;
            bias_rf1_wr_data <= '0;
            bias_rf2_wr_data <= '0;
            bias_rf3_wr_data <= '0;
            bias_rf4_wr_data <= '0;
            busy             <= 1'b0;
            load_done        <= 1'b0;
            for (int i = 0; i < BIAS_LANES; i++) stage[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        busy            <= 1'b1;
                        count           <= '0;
                        lane_idx        <= '0;
                        bias_rf_wr_addr <= '0;
                        for (int i = 0; i < BIAS_LANES; i++) stage[i] <= '0;
                        if (load_num == '0) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            n             <= n_clamped;
                            state         <= COLLECT;
                            bias_in_ready <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (hs) begin
                        stage[lane_idx] <= bias_in_data;
                        lane_idx        <= lane_idx + 2'd1;
                        count           <= cnt_inc;
                        // Group complete (full or final partial): present the
                        // staged lanes merged with the word arriving now.
                        if (lane_idx == 2'd3 || cnt_inc == n) begin
                            state            <= WRITE;
                            bias_in_ready    <= 1'b0;
                            bias_rf_en       <= 1'b0;
                            bias_rf_wr_en    <= 1'b0;
                            bias_rf1_wr_data <= (lane_idx == 2'd0) ? bias_in_data : stage[0];
                            bias_rf2_wr_data <= (lane_idx == 2'd1) ? bias_in_data : stage[1];
                            bias_rf3_wr_data <= (lane_idx == 2'd2) ? bias_in_data : stage[2];
                            bias_rf4_wr_data <= (lane_idx == 2'd3) ? bias_in_data : stage[3];
                        end
                    end
                end

                WRITE: begin
                    bias_rf_en      <= 1'b1;
                    bias_rf_wr_en   <= 1'b1;
                    bias_rf_wr_addr <= bias_rf_wr_addr + ADDR_W'(1);
                    // Cleared stage makes unfilled lanes of a partial group write 0.
                    for (int i = 0; i < BIAS_LANES; i++) stage[i] <= '0;
                    if (count == n) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                    end else begin
                        state         <= COLLECT;
                        bias_in_ready <= 1'b1;
                    end
                end

                DONE: begin
                    load_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule : bias_rf_loader

// File: tb/tb_bias_rf_loader.sv
// Self-checking bench for bias_rf_loader: table of loads applied through a
// randomized stream driver, checked against a channel->lane/address model and
// an SRAM image, plus a hand-written mid-load reset sequence.
module tb_bias_rf_loader;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned CW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic [CW-1:0] load_num = '0;
    logic          bias_in_valid = 1'b0;
    logic          bias_in_ready;
    logic [DW-1:0] bias_in_data = '0;
    logic          bias_rf_en;
    logic          bias_rf_wr_en;
    logic [AW-1:0] bias_rf_wr_addr;
    logic [DW-1:0] bias_rf1_wr_data;
    logic [DW-1:0] bias_rf2_wr_data;
    logic [DW-1:0] bias_rf3_wr_data;
    logic [DW-1:0] bias_rf4_wr_data;
    logic          busy;
    logic          load_done;

    bias_rf_loader dut (
        .clk              (clk),
        .rst              (rst),
        .load_start       (load_start),
        .load_num         (load_num),
        .bias_in_valid    (bias_in_valid),
        .bias_in_ready    (bias_in_ready),
        .bias_in_data     (bias_in_data),
        .bias_rf_en       (bias_rf_en),
        .bias_rf_wr_en    (bias_rf_wr_en),
        .bias_rf_wr_addr  (bias_rf_wr_addr),
        .bias_rf1_wr_data (bias_rf1_wr_data),
        .bias_rf2_wr_data (bias_rf2_wr_data),
        .bias_rf3_wr_data (bias_rf3_wr_data),
        .bias_rf4_wr_data (bias_rf4_wr_data),
        .busy             (busy),
        .load_done        (load_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    num;          // load_num
        int    nwords;       // words offered on the stream
        int    mode;         // 0: 1,2,3..  1: -1,-2,..  2: random
        bit    gaps;         // random valid gaps
        bit    extra_start;  // pulse load_start again mid-load
        int    exp_writes;
        int    exp_accept;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int accepted;
    int en_split = 0;

    logic [DW-1:0] words [128];
    logic [DW-1:0] mem   [4][16];
    int            wr_addr_q[$];
    int            wr_cyc_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            done_cyc_q[$];

    always @(posedge clk) cyc++;

    // SRAM model and write/done log, sampled mid-cycle.
    always @(negedge clk) begin
        if (bias_rf_en != bias_rf_wr_en) en_split++;
        if (!bias_rf_en && !bias_rf_wr_en) begin
            wr_addr_q.push_back(int'(bias_rf_wr_addr));
            wr_cyc_q.push_back(cyc);
            wr_data_q.push_back(bias_rf1_wr_data);
            wr_data_q.push_back(bias_rf2_wr_data);
            wr_data_q.push_back(bias_rf3_wr_data);
            wr_data_q.push_back(bias_rf4_wr_data);
            mem[0][bias_rf_wr_addr] = bias_rf1_wr_data;
            mem[1][bias_rf_wr_addr] = bias_rf2_wr_data;
            mem[2][bias_rf_wr_addr] = bias_rf3_wr_data;
            mem[3][bias_rf_wr_addr] = bias_rf4_wr_data;
        end
        if (load_done) done_cyc_q.push_back(cyc);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " cen"},   int'(bias_rf_en), 1);
        check({tag, " wen"},   int'(bias_rf_wr_en), 1);
        check({tag, " addr"},  int'(bias_rf_wr_addr), 0);
        check({tag, " data"},  int'(bias_rf1_wr_data | bias_rf2_wr_data |
                                    bias_rf3_wr_data | bias_rf4_wr_data), 0);
        check({tag, " ready"}, int'(bias_in_ready), 0);
        check({tag, " busy"},  int'(busy), 0);
        check({tag, " done"},  int'(load_done), 0);
    endtask

    task automatic fill_words(input int mode, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            case (mode)
                0:       words[i] = DW'(i + 1);
                1:       words[i] = DW'(-(i + 1));
                default: words[i] = DW'($urandom);
            endcase
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_cyc_q.delete();
        wr_data_q.delete();
        done_cyc_q.delete();
        accepted = 0;
        en_split = 0;
    endtask

    task automatic run_load(input vec_t v);
        int idx;
        int tail;
        int start_cyc;
        int n_eff;
        int bad;
        bit hs;
        bit finished;
        logic [DW-1:0] exp_d;

        fill_words(v.mode, v.nwords);
        clear_logs();
        @(negedge clk);
        load_start = 1'b1;
        load_num   = CW'(v.num);
        start_cyc  = cyc;
        idx = 0; tail = 0; hs = 1'b0; finished = 1'b0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            @(negedge clk);
            if (hs) idx++;
            load_start = (v.extra_start && c == 3);
            if (load_start) load_num = CW'(7);
            bias_in_valid = (idx < v.nwords) && (!v.gaps || $urandom_range(0, 2) != 0);
            bias_in_data  = bias_in_valid ? words[idx] : DW'($urandom);
            hs = bias_in_valid && bias_in_ready;
            if (hs) accepted++;
            if (done_cyc_q.size() > 0) begin
                tail++;
                if (tail > 4) finished = 1'b1;
            end
        end
        bias_in_valid = 1'b0;
        load_start    = 1'b0;

        check({v.name, " completes"}, int'(finished), 1);
        check({v.name, " writes"},    wr_addr_q.size(), v.exp_writes);
        check({v.name, " accepted"},  accepted, v.exp_accept);
        check({v.name, " done pulses"}, done_cyc_q.size(), 1);
        check({v.name, " cen/wen split"}, en_split, 0);
        check({v.name, " busy after"}, int'(busy), 0);

        n_eff = (v.num > 64) ? 64 : v.num;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            check($sformatf("%s write%0d addr", v.name, i), wr_addr_q[i], i);
            for (int k = 0; k < 4; k++) begin
                exp_d = (4 * i + k < n_eff) ? words[4 * i + k] : '0;
                check($sformatf("%s addr%0d lane%0d", v.name, i, k),
                      int'(wr_data_q[4 * i + k]), int'(exp_d));
            end
        end

        if (done_cyc_q.size() > 0) begin
            if (wr_cyc_q.size() > 0)
                check({v.name, " done latency"}, done_cyc_q[0], wr_cyc_q[wr_cyc_q.size() - 1] + 1);
            else
                check({v.name, " done latency"}, done_cyc_q[0], start_cyc + 1);
        end

        if (n_eff > 0) begin
            bad = 0;
            for (int c = 0; c < n_eff; c++)
                if (mem[c % 4][c / 4] !== words[c]) bad++;
            check({v.name, " sram readback"}, bad, 0);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int  idx;
        bit  hs;
        vec_t v;

        vecs[0] = '{"ramp8",      8,   8, 0, 1'b0, 1'b0,  2,  8};
        vecs[1] = '{"neg6",       6,   6, 1, 1'b0, 1'b0,  2,  6};
        vecs[2] = '{"full64",    64,  64, 2, 1'b1, 1'b0, 16, 64};
        vecs[3] = '{"zero",       0,   4, 2, 1'b0, 1'b0,  0,  0};
        vecs[4] = '{"clamp100", 100, 100, 2, 1'b1, 1'b0, 16, 64};
        vecs[5] = '{"single",     1,   1, 2, 1'b0, 1'b0,  1,  1};
        vecs[6] = '{"restart5",   5,   5, 2, 1'b1, 1'b1,  2,  5};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        foreach (vecs[i]) run_load(vecs[i]);

        // Mid-load reset after five accepted words.
        fill_words(0, 8);
        clear_logs();
        @(negedge clk);
        load_start = 1'b1;
        load_num   = CW'(8);
        idx = 0; hs = 1'b0;
        for (int c = 0; c < 200 && accepted < 5; c++) begin
            @(negedge clk);
            load_start = 1'b0;
            if (hs) idx++;
            bias_in_valid = 1'b1;
            bias_in_data  = words[idx];
            hs = bias_in_valid && bias_in_ready;
            if (hs) accepted++;
        end
        check("abort accepted", accepted, 5);
        @(negedge clk);
        rst = 1'b1;
        bias_in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort no done", done_cyc_q.size(), 0);
        check("abort writes", wr_addr_q.size(), 1);
        check("abort retained", int'(mem[3][0]), 4);

        v = '{"after_abort", 4, 4, 2, 1'b0, 1'b0, 1, 4};
        run_load(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_bias_rf_loader
